// File: rtl/fcore_gatherer_pkg.sv
// Shared types for the fCore input gatherer.
//   state_t      : round sequencing states (collect samples, fire start, wait for core)
//   map_entry_t  : one channel map entry {DMA address, round participation enable}
//   MAP_ADDR_WIDTH is the address width carried by a map entry; the top-level
//   ADDR_WIDTH parameter defaults to it and the two are expected to match.
package fcore_gatherer_pkg;

  localparam int MAP_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_START,
    ST_RUN
  } state_t;

  typedef struct packed {
    logic [MAP_ADDR_WIDTH-1:0] addr;
    logic                      enable;
  } map_entry_t;

endpackage

// File: rtl/fcore_channel_map.sv
// Channel map register file: channel id -> {DMA address, enable}.
// Ports:
//   clock, reset          : system clock, synchronous active-high reset
//   cfg_write/index/entry : write port; indices >= N_CHANNELS are ignored,
//                           new contents visible from the next cycle
//   rd_index              : combinational lookup key (stream channel id)
//   rd_entry              : entry addressed by rd_index (zero when out of range)
//   rd_sel                : one-hot of the matching entry (all zero when out of range)
//   enable_mask           : enable bit of every entry, bit i = entry i
module fcore_channel_map
  import fcore_gatherer_pkg::*;
#(
  parameter int N_CHANNELS = 8,
  parameter int CH_WIDTH   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cfg_write,
  input  logic [CH_WIDTH-1:0]   cfg_index,
  input  map_entry_t            cfg_entry,
  input  logic [CH_WIDTH-1:0]   rd_index,
  output map_entry_t            rd_entry,
  output logic [N_CHANNELS-1:0] rd_sel,
  output logic [N_CHANNELS-1:0] enable_mask
);

  map_entry_t map_q [N_CHANNELS];

  // NOTE: the table is reset on purpose so a fresh round starts with every
  // channel disabled; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_CHANNELS; i++) map_q[i] <= '0;
    end else if (cfg_write) begin
      // Comparing against every legal index drops out-of-range writes for free.
      for (int i = 0; i < N_CHANNELS; i++) begin
        if (cfg_index == CH_WIDTH'(i)) map_q[i] <= cfg_entry;
      end
    end
  end

  // NOTE: every output gets a default before the loop so no latch is inferred
  // when rd_index matches no entry.
  always_comb begin
    rd_entry    = '0;
    rd_sel      = '0;
    enable_mask = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      enable_mask[i] = map_q[i].enable;
      if (rd_index == CH_WIDTH'(i)) begin
        rd_sel[i] = 1'b1;
        rd_entry  = map_q[i];
      end
    end
  end

endmodule

// File: rtl/fcore_input_gatherer.sv
// Collects one sample per enabled channel from an AXI-stream source, writes
// each sample into the fCore DMA port at its mapped address, then pulses
// core_start and stalls the stream until the core reports completion.
// Ports:
//   clock, reset                     : system clock, synchronous active-high reset
//   s_data/s_dest/s_valid/s_ready    : sample stream (s_dest = channel id)
//   cfg_write/index/addr/enable      : channel map programming port
//   dma_valid/dma_addr/dma_data      : registered DMA write to the core
//   core_start                       : one-cycle start pulse after the last write
//   core_done                        : one-cycle completion pulse from the core
//   bad_dest                         : sticky flag, an out-of-range id was seen
module fcore_input_gatherer
  import fcore_gatherer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CH_WIDTH   = 4,
  parameter int N_CHANNELS = 8,
  parameter int ADDR_WIDTH = MAP_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [CH_WIDTH-1:0]   s_dest,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  cfg_write,
  input  logic [CH_WIDTH-1:0]   cfg_index,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic                  cfg_enable,
  output logic                  dma_valid,
  output logic [ADDR_WIDTH-1:0] dma_addr,
  output logic [DATA_WIDTH-1:0] dma_data,
  output logic                  core_start,
  input  logic                  core_done,
  output logic                  bad_dest
);

  state_t                  state;
  logic [N_CHANNELS-1:0]   received;
  logic [N_CHANNELS-1:0]   received_next;
  logic [N_CHANNELS-1:0]   rd_sel;
  logic [N_CHANNELS-1:0]   enable_mask;
  map_entry_t              rd_entry;
  map_entry_t              cfg_entry;
  logic                    handshake;
  logic                    round_done;

  assign cfg_entry = '{addr: MAP_ADDR_WIDTH'(cfg_addr), enable: cfg_enable};
  assign handshake = s_valid & s_ready;

  fcore_channel_map #(
    .N_CHANNELS (N_CHANNELS),
    .CH_WIDTH   (CH_WIDTH)
  ) u_map (
    .clock       (clock),
    .reset       (reset),
    .cfg_write   (cfg_write),
    .cfg_index   (cfg_index),
    .cfg_entry   (cfg_entry),
    .rd_index    (s_dest),
    .rd_entry    (rd_entry),
    .rd_sel      (rd_sel),
    .enable_mask (enable_mask)
  );

  // Only enabled channels count towards the round; an empty mask never
  // completes, so the gatherer then just forwards samples indefinitely.
  always_comb begin
    received_next = received | (rd_entry.enable ? rd_sel : '0);
    round_done    = ((received_next & enable_mask) == enable_mask) && (|enable_mask);
  end

  // NOTE: all state here is sequential and uses non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_COLLECT;
      s_ready    <= 1'b0;
      received   <= '0;
      dma_valid  <= 1'b0;
      dma_addr   <= '0;
      dma_data   <= '0;
      core_start <= 1'b0;
      bad_dest   <= 1'b0;
    end else begin
      dma_valid  <= 1'b0;
      core_start <= 1'b0;
      case (state)
        ST_COLLECT: begin
          s_ready <= 1'b1;
          if (handshake) begin
            if (|rd_sel) begin
              // Disabled channels and duplicates are still written; the core
              // simply sees the most recent value.
              dma_valid <= 1'b1;
              dma_addr  <= ADDR_WIDTH'(rd_entry.addr);
              dma_data  <= s_data;
              received  <= received_next;
              if (round_done) begin
                state   <= ST_START;
                s_ready <= 1'b0;
              end
            end else begin
              bad_dest <= 1'b1;
            end
          end
        end
        ST_START: begin
          // Entered the cycle the last write is on the DMA port, so the
          // start pulse lands strictly after it.
          s_ready    <= 1'b0;
          core_start <= 1'b1;
          received   <= '0;
          state      <= ST_RUN;
        end
        ST_RUN: begin
          s_ready <= 1'b0;
          if (core_done) begin
            state   <= ST_COLLECT;
            s_ready <= 1'b1;
          end
        end
        default: begin
          state   <= ST_COLLECT;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fcore_input_gatherer.sv
module tb_fcore_input_gatherer;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int NC = 8;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic [CW-1:0] s_dest = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          cfg_write = 1'b0;
  logic [CW-1:0] cfg_index = '0;
  logic [AW-1:0] cfg_addr = '0;
  logic          cfg_enable = 1'b0;
  logic          dma_valid;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_data;
  logic          core_start;
  logic          core_done = 1'b0;
  logic          bad_dest;

  fcore_input_gatherer #(
    .DATA_WIDTH (DW),
    .CH_WIDTH   (CW),
    .N_CHANNELS (NC),
    .ADDR_WIDTH (AW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .s_data     (s_data),
    .s_dest     (s_dest),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .cfg_write  (cfg_write),
    .cfg_index  (cfg_index),
    .cfg_addr   (cfg_addr),
    .cfg_enable (cfg_enable),
    .dma_valid  (dma_valid),
    .dma_addr   (dma_addr),
    .dma_data   (dma_data),
    .core_start (core_start),
    .core_done  (core_done),
    .bad_dest   (bad_dest)
  );

  always #5 clock = ~clock;

  // Cycle index: number of rising edges so far, read on falling edges.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Observed traffic, captured mid-cycle.
  logic [AW-1:0] got_addr[$];
  logic [DW-1:0] got_data[$];
  int            got_cyc[$];
  int            start_cnt = 0;
  int            start_cyc = -1;

  always @(negedge clock) begin
    if (dma_valid === 1'b1) begin
      got_addr.push_back(dma_addr);
      got_data.push_back(dma_data);
      got_cyc.push_back(cyc);
    end
    if (core_start === 1'b1) begin
      start_cnt++;
      start_cyc = cyc;
    end
  end

  // Reference model: the map table, the set of channels seen this round,
  // expected DMA writes and expected number of start pulses.
  logic [AW-1:0] m_addr[NC];
  bit            m_en[NC];
  bit            m_rcv[NC];
  bit            m_bad;
  int            m_starts = 0;
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];
  int            hs_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_addr[i] = '0;
      m_en[i]   = 1'b0;
      m_rcv[i]  = 1'b0;
    end
    m_bad = 1'b0;
  endtask

  task automatic model_sample(input int d, input logic [DW-1:0] v, output bit fin);
    bit any_en;
    bit all_in;
    fin = 1'b0;
    if (d >= NC) begin
      m_bad = 1'b1;
      return;
    end
    exp_addr.push_back(m_addr[d]);
    exp_data.push_back(v);
    if (m_en[d]) m_rcv[d] = 1'b1;
    any_en = 1'b0;
    all_in = 1'b1;
    for (int i = 0; i < NC; i++) begin
      if (m_en[i]) begin
        any_en = 1'b1;
        if (!m_rcv[i]) all_in = 1'b0;
      end
    end
    if (any_en && all_in) begin
      fin = 1'b1;
      m_starts++;
      for (int i = 0; i < NC; i++) m_rcv[i] = 1'b0;
    end
  endtask

  // All driving tasks start and end on a falling edge.
  task automatic cfg(input int idx, input logic [AW-1:0] a, input bit en);
    cfg_write  = 1'b1;
    cfg_index  = CW'(idx);
    cfg_addr   = a;
    cfg_enable = en;
    @(negedge clock);
    cfg_write = 1'b0;
    if (idx < NC) begin
      m_addr[idx] = a;
      m_en[idx]   = en;
    end
  endtask

  task automatic send(input int d, input logic [DW-1:0] v, output bit fin);
    int waited;
    waited  = 0;
    s_valid = 1'b1;
    s_dest  = CW'(d);
    s_data  = v;
    while (s_ready !== 1'b1 && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    check("send_ready", s_ready, 1);
    hs_cyc = cyc;
    @(negedge clock);
    model_sample(d, v, fin);
  endtask

  task automatic idle();
    s_valid = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    @(negedge clock);
    core_done = 1'b0;
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_wr_count"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check({tag, "_wr_addr"}, got_addr[i], exp_addr[i]);
      check({tag, "_wr_data"}, got_data[i], exp_data[i]);
    end
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic wait_start(input string tag);
    int waited;
    waited = 0;
    while (start_cnt != m_starts && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    check(tag, start_cnt, m_starts);
  endtask

  task automatic do_reset(input int n);
    idle();
    reset = 1'b1;
    repeat (n) @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fin;
    int n;
    int k;
    bit any;

    model_reset();

    // Reset values.
    settle(3);
    check("rst_s_ready", s_ready, 0);
    check("rst_dma_valid", dma_valid, 0);
    check("rst_dma_addr", dma_addr, 0);
    check("rst_dma_data", dma_data, 0);
    check("rst_core_start", core_start, 0);
    check("rst_bad_dest", bad_dest, 0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_s_ready", s_ready, 1);

    // Basic round with latency checks.
    cfg(0, 8'd1, 1'b1);
    cfg(1, 8'd2, 1'b1);
    send(0, 32'h100, fin);
    n = hs_cyc;
    send(1, 32'h200, fin);
    idle();
    settle(4);
    check("t1_wr0_cycle", got_cyc.size() > 0 ? got_cyc[0] : -1, n + 1);
    check("t1_wr1_cycle", got_cyc.size() > 1 ? got_cyc[1] : -1, n + 2);
    check("t1_start_cycle", start_cyc, n + 3);
    check("t1_start_count", start_cnt, m_starts);
    compare_writes("t1");
    check("t1_run_s_ready", s_ready, 0);
    pulse_done();
    check("t1_done_s_ready", s_ready, 1);

    // Duplicate channel within a round.
    send(0, 32'h10, fin);
    send(0, 32'h11, fin);
    send(1, 32'h22, fin);
    idle();
    wait_start("t2_start_count");
    settle(3);
    check("t2_single_start", start_cnt, m_starts);
    compare_writes("t2");
    pulse_done();

    // Invalid channel id, sticky across a round.
    send(9, 32'hdead, fin);
    idle();
    settle(2);
    compare_writes("t3_bad");
    check("t3_bad_dest", bad_dest, 1);
    send(0, 32'h31, fin);
    send(1, 32'h32, fin);
    idle();
    wait_start("t3_start_count");
    compare_writes("t3_round");
    pulse_done();
    settle(1);
    check("t3_bad_sticky", bad_dest, 1);

    // core_done during COLLECT is ignored.
    send(0, 32'h61, fin);
    idle();
    pulse_done();
    check("t6_s_ready", s_ready, 1);
    settle(2);
    check("t6_no_start", start_cnt, m_starts);
    send(1, 32'h62, fin);
    idle();
    wait_start("t6_start_count");
    compare_writes("t6");
    pulse_done();

    // Reset in the middle of a round.
    send(0, 32'h51, fin);
    idle();
    settle(1);
    compare_writes("t5_pre");
    do_reset(2);
    check("t5_s_ready", s_ready, 1);
    check("t5_bad_cleared", bad_dest, 0);
    send(1, 32'h55, fin);
    idle();
    settle(4);
    check("t5_no_start_a", start_cnt, m_starts);
    compare_writes("t5_cleared_map");
    cfg(0, 8'd1, 1'b1);
    cfg(1, 8'd2, 1'b1);
    send(1, 32'h56, fin);
    idle();
    settle(4);
    check("t5_no_start_b", start_cnt, m_starts);
    send(0, 32'h57, fin);
    idle();
    wait_start("t5_start_count");
    compare_writes("t5_round");
    pulse_done();

    // Empty enable mask: samples forwarded, no start.
    cfg(0, 8'd1, 1'b0);
    cfg(1, 8'd2, 1'b0);
    for (int i = 0; i < 5; i++) send(int'($urandom_range(0, NC - 1)), $urandom, fin);
    idle();
    settle(5);
    check("t4_no_start", start_cnt, m_starts);
    check("t4_s_ready", s_ready, 1);
    compare_writes("t4");

    // Randomized rounds.
    for (int r = 0; r < 25; r++) begin
      any = 1'b0;
      for (int i = 0; i < NC; i++) begin
        cfg(i, AW'($urandom), 1'($urandom_range(0, 1)));
        if (m_en[i]) any = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) cfg(NC + int'($urandom_range(0, 7)), AW'($urandom), 1'b1);
      if (!any) cfg(int'($urandom_range(0, NC - 1)), AW'($urandom), 1'b1);
      fin = 1'b0;
      k = 0;
      while (!fin && k < 12) begin
        send(int'($urandom_range(0, 9)), $urandom, fin);
        k++;
      end
      for (int i = 0; i < NC; i++) begin
        if (!fin && m_en[i] && !m_rcv[i]) send(i, $urandom, fin);
      end
      idle();
      wait_start("rnd_start_count");
      check("rnd_run_s_ready", s_ready, 0);
      if ($urandom_range(0, 1) == 1) cfg(int'($urandom_range(0, NC - 1)), AW'($urandom), 1'($urandom_range(0, 1)));
      settle(int'($urandom_range(0, 3)));
      pulse_done();
      check("rnd_done_s_ready", s_ready, 1);
      settle(1);
      compare_writes("rnd");
      check("rnd_bad_dest", bad_dest, m_bad);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fcore_input_gatherer.md
# fcore_input_gatherer

Upstream feeder for an fCore processor instance in the SiC drive current-control path. It collects one sample per configured channel from an AXI-stream source (ADC/encoder front ends, e.g. Current and Speed), translates each channel id to the processor's DMA input address, writes it into the core's DMA port, and fires the core start pulse once every enabled channel has been written. It stalls the stream until the core reports completion, so each control round sees a coherent input set.

## Interface
- DATA_WIDTH, 32, sample and DMA data width
- CH_WIDTH, 4, width of stream tdest (channel id)
- N_CHANNELS, 8, channel map entries; ids >= N_CHANNELS are invalid
- ADDR_WIDTH, 8, processor DMA address width
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- s_data  in  DATA_WIDTH  sample payload
- s_dest  in  CH_WIDTH  channel id
- s_valid  in  1  sample valid
- s_ready  out  1  sample ready
- cfg_write  in  1  map entry write strobe
- cfg_index  in  CH_WIDTH  entry index
- cfg_addr  in  ADDR_WIDTH  DMA address for entry
- cfg_enable  in  1  entry participates in round
- dma_valid  out  1  DMA write strobe
- dma_addr  out  ADDR_WIDTH  DMA write address
- dma_data  out  DATA_WIDTH  DMA write data
- core_start  out  1  one-cycle start pulse to core
- core_done  in  1  one-cycle completion pulse from core
- bad_dest  out  1  sticky: invalid channel id received

## Operation
- Map table: N_CHANNELS entries of {addr, enable}; cfg_write with cfg_index < N_CHANNELS updates entry, effective from next cycle; cfg_index out of range ignored.
- FSM states COLLECT, START, RUN.
- COLLECT: s_ready=1. Handshake = s_valid & s_ready. Valid id: DMA write to map[id].addr with s_data; if enabled, set received[id]. Invalid id: sample consumed and dropped, bad_dest set (cleared only by reset). Disabled entry: write still issued, mask unaffected.
- Duplicate id within a round: DMA write reissued (latest value wins), mask unchanged.
- Round complete when (received & enable_mask) == enable_mask and enable_mask != 0 → go to START; s_ready drops the cycle after the completing handshake.
- Empty enable mask: never leaves COLLECT, samples still forwarded.
- START: core_start=1 for exactly one cycle, received cleared, → RUN.
- RUN: s_ready=0; on core_done → COLLECT. core_done in COLLECT/START ignored.
- Config writes during RUN allowed; apply to next round.

## Timing
- Reset values: s_ready 0, dma_valid 0, dma_addr 0, dma_data 0, core_start 0, bad_dest 0, table cleared (all disabled, addr 0), received 0, state COLLECT. s_ready=1 from first cycle after reset deasserts.
- DMA write latency: handshake at cycle N → dma_valid/addr/data registered at N+1, one write per cycle, back-to-back sustained.
- Completing handshake at N → DMA write at N+1, core_start at N+2 (strictly after last write).
- core_done at M → s_ready=1 at M+1.
- Reset mid-round: mask and state cleared same cycle; no core_start issued; partial writes already sent not retracted.

## Structure
- Package fcore_gatherer_pkg: state enum, map entry struct {addr, enable}.
- Sub-module fcore_channel_map: register-file map table with write port and combinational read by s_dest plus enable_mask vector output. Rest (FSM, mask, DMA output regs) in top.

## Test plan
- Map ch0→1, ch1→2 enabled; send ch0=0x100, ch1=0x200 consecutive → dma writes (1,0x100),(2,0x200) on N+1,N+2; core_start at N+3; s_ready low until core_done, high one cycle later.
- Send ch0 twice (0x10, 0x11) then ch1 → three DMA writes, last to addr 1 is 0x11; single core_start.
- s_dest=9 with N_CHANNELS=8 → no dma_valid, bad_dest=1 and stays 1 across rounds.
- Enable mask all zero, stream 5 samples → 5 DMA writes, no core_start.
- Assert reset after ch0 only, then send ch1 → no core_start until ch0 resent (table must be reprogrammed).
- core_done pulsed during COLLECT → ignored; state and s_ready unchanged.
